aes_key_schedule_seq: RTL and testbench
=======================================

# aes_key_schedule_seq

Sequential, run-time-configurable AES key schedule generator supporting 128/192/256-bit keys. It produces one 32-bit schedule word per cycle and delivers each 128-bit round key over a valid/ready port to the cipher datapath. It is the iterative, multi-mode successor to the combinational 256-bit expansion stage. It reuses the existing combinational `sbox` module, with four instances in total.

## Interface
- `MODE_MASK`, default 3'b111: legal key sizes; bit0 = 128, bit1 = 192, bit2 = 256.
- `RK_IDX_W`, default 4: width of the round-key index output.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request a schedule run; sampled in IDLE only.
- `key_mode` in 2: 00 = 128, 01 = 192, 10 = 256, 11 = illegal.
- `key` in 256: key, left-aligned. Word0 is `key[255:224]`. A 128-bit key occupies `[255:128]`; a 192-bit key occupies `[255:64]`.
- `abort` in 1: synchronous cancel of the current run.
- `rk_data` out 128: round key, `{w[4r], w[4r+1], w[4r+2], w[4r+3]}`.
- `rk_idx` out `RK_IDX_W`: round index r of `rk_data`.
- `rk_valid` out 1: `rk_data` and `rk_idx` are valid.
- `rk_ready` in 1: consumer accepts the current round key.
- `busy` out 1: a run is in progress.
- `done` out 1: one-cycle pulse when the final round key is accepted.
- `err` out 1: one-cycle pulse when a `start` with an illegal or masked mode is rejected.

## Operation
- Per-mode constants: Nk = 4/6/8, Nr = 10/12/14, total words 44/52/60.
- States: IDLE and RUN.
- Leaving IDLE:
  - `start` with a legal mode: latch `key` and `key_mode`, clear the word counter i to 0, set Rcon to 8'h01, go to RUN.
  - `start` with mode 11 or a mode masked off by `MODE_MASK`: pulse `err`, stay in IDLE.
  - `start` while in RUN is ignored. `key` and `key_mode` changes during RUN are ignored.
- Word generation in RUN advances only when the output slot is free: `!(rk_valid && !rk_ready)`.
- Schedule word w[i]:
  - i < Nk: w[i] is word i of the latched key.
  - i mod Nk == 0: w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {Rcon, 24'h0}. Rcon then advances by xtime (multiply by 2, reduce with 8'h1B): 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
  - Nk == 8 and i mod 8 == 4: w[i] = w[i-8] ^ SubWord(w[i-1]). No rotate, no Rcon.
  - Otherwise: w[i] = w[i-Nk] ^ w[i-1].
- Storage: an 8-word sliding window of w[i-8..i-1] plus a 3-word partial round-key buffer.
- When i mod 4 == 3, the completed key `{w[i-3..i]}` loads into `rk_data`, with `rk_idx = i>>2` and `rk_valid = 1`.
- Output handshake:
  - A round key transfers on a cycle where `rk_valid && rk_ready`. Without a new load on that edge, `rk_valid` clears.
  - `rk_data` and `rk_idx` stay stable while `rk_valid && !rk_ready`.
- Completion: when round key Nr transfers, pulse `done`, clear `busy`, return to IDLE.
- `abort` in RUN: next edge goes to IDLE, clears `rk_valid` and `busy`, no `done`. `abort` in IDLE has no effect. `abort` has priority over generation and completion in the same cycle.
- `rk_idx` never exceeds Nr. No round keys are emitted after `done`.

## Timing
- Reset values: all outputs 0; state IDLE; i = 0; Rcon = 8'h01; window and buffer cleared.
- `start` accepted at edge E0: `busy` = 1 after E0.
- With `rk_ready` held high, word i is registered at edge E(i+1).
- Round key r is valid after E(4r+4), for exactly one cycle.
- Last key: 128-bit after E44, 192-bit after E52, 256-bit after E60. `done` is high in that same cycle, `busy` falls after the next edge, and the next `start` is accepted on that following edge.
- Each cycle of `rk_valid && !rk_ready` adds exactly one cycle of stall. No words are lost or duplicated.
- `err` pulses in the cycle after the rejected `start`.
- Reset asserted mid-run: immediate return to reset values.

## Test plan
- FIPS-197 A.1: key 2b7e1516 28aed2a6 abf71588 09cf4f3c, `rk_ready` = 1.
  - rk0 equals the key; rk1 = a0fafe17 88542cb1 23a33939 2a6c7605; rk10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - `done` occurs in the cycle after E44; 11 `rk_valid` pulses total.
- FIPS-197 A.2: key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b.
  - rk12 = e98ba06f 448c773c 8ecc7204 01002202; 13 round keys.
- FIPS-197 A.3: key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4.
  - w8 = 9ba35411; w12 = a8b09c1a (SubWord-only path); rk14 = fe4890d1 e6188d0b 046df344 706c631e.
- A.1 vector with `rk_ready` randomly deasserted about 50% of cycles.
  - Identical key sequence; `rk_data` stable while stalled; `rk_idx` strictly 0..10.
- Error and control cases:
  - `start` with `key_mode` = 11 gives an `err` pulse and `busy` stays 0.
  - With `MODE_MASK` = 3'b001, a 256-bit start gives `err`.
  - `start` during RUN is ignored.
- Abort and reset:
  - `abort` after rk3: next cycle `busy` = 0, `rk_valid` = 0, no `done`. A restart with the A.1 key reproduces rk0..rk10 exactly.
  - `rst_n` low mid-run: all outputs 0 asynchronously.

Source files
------------

// File: rtl/aes_key_schedule_seq.sv
// AES S-box lookup and sequential AES key schedule (128/192/256-bit keys).
// The schedule emits one 32-bit word per cycle and hands out each 128-bit
// round key over a valid/ready port.

module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // FIPS-197 S-box; byte a sits at bit offset 8*(255-a) == {~a, 3'b000}
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Combinational table lookup
    always_comb begin
        y = SBOX[{~a, 3'b000} +: 8];
    end
endmodule

module aes_key_schedule_seq #(
    parameter logic [2:0]  MODE_MASK = 3'b111,
    parameter int unsigned RK_IDX_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          key_mode,
    input  logic [255:0]        key,
    input  logic                abort,
    output logic [127:0]        rk_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]   state;
    logic [1:0]   mode_q;
    logic [255:0] key_q;
    logic [5:0]   i;        // index of the next schedule word
    logic [2:0]   j;        // i mod Nk, kept as a wrapping counter
    logic [7:0]   rcon;
    logic [31:0]  win [8];  // win[7] = w[i-1] ... win[0] = w[i-8]
    logic [31:0]  pbuf [3]; // words of the round key being assembled
    logic         err_q;

    logic [5:0]   nk;
    logic [5:0]   total;
    logic [3:0]   nr;
    logic [31:0]  kw [8];
    logic [31:0]  prev_w, back_w, sub_in, sub_out, w_new;
    logic         legal, advance, xfer, done_c;

    // Per-mode constants of the latched run
    always_comb begin
        case (mode_q)
            2'b00:   begin nk = 6'd4; total = 6'd44; nr = 4'd10; end
            2'b01:   begin nk = 6'd6; total = 6'd52; nr = 4'd12; end
            default: begin nk = 6'd8; total = 6'd60; nr = 4'd14; end
        endcase
    end

    // Next schedule word and handshake qualifiers
    always_comb begin
        for (int unsigned n = 0; n < 8; n++) begin
            kw[n] = key_q[255 - 32*n -: 32];
        end
        prev_w = win[7];
        back_w = win[3'(6'd8 - nk)];
        sub_in = (j == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        if (i < nk)
            w_new = kw[i[2:0]];
        else if (j == 3'd0)
            w_new = back_w ^ sub_out ^ {rcon, 24'h0};
        else if (nk == 6'd8 && j == 3'd4)
            w_new = back_w ^ sub_out;
        else
            w_new = back_w ^ prev_w;

        legal   = (key_mode == 2'b00 && MODE_MASK[0]) ||
                  (key_mode == 2'b01 && MODE_MASK[1]) ||
                  (key_mode == 2'b10 && MODE_MASK[2]);
        xfer    = rk_valid && rk_ready;
        advance = (state == RUN) && (i < total) && !(rk_valid && !rk_ready);
        done_c  = (state == RUN) && !abort && xfer && (rk_idx == RK_IDX_W'(nr));
    end

    for (genvar b = 0; b < 4; b++) begin : g_sub
        sbox u_sbox (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
    end

    assign busy = (state == RUN);
    assign done = done_c;
    assign err  = err_q;

    // Run control, word generation and round-key output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mode_q   <= 2'b00;
            key_q    <= '0;
            i        <= '0;
            j        <= '0;
            rcon     <= 8'h01;
            err_q    <= 1'b0;
            rk_data  <= '0;
            rk_idx   <= '0;
            rk_valid <= 1'b0;
            for (int unsigned n = 0; n < 8; n++) win[n] <= '0;
            for (int unsigned n = 0; n < 3; n++) pbuf[n] <= '0;
        end else begin
            err_q <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    if (legal) begin
                        state  <= RUN;
                        key_q  <= key;
                        mode_q <= key_mode;
                        i      <= '0;
                        j      <= '0;
                        rcon   <= 8'h01;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
            end else if (abort) begin
                state    <= IDLE;
                rk_valid <= 1'b0;
            end else begin
                if (xfer) rk_valid <= 1'b0;
                if (done_c) state <= IDLE;
                if (advance) begin
                    for (int unsigned n = 0; n < 7; n++) win[n] <= win[n+1];
                    win[7] <= w_new;
                    i <= i + 6'd1;
                    j <= ({3'b000, j} == nk - 6'd1) ? 3'd0 : j + 3'd1;
                    if (i >= nk && j == 3'd0)
                        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    // a load on the same edge as a transfer keeps rk_valid high
                    case (i[1:0])
                        2'd0: pbuf[0] <= w_new;
                        2'd1: pbuf[1] <= w_new;
                        2'd2: pbuf[2] <= w_new;
                        default: begin
                            rk_data  <= {pbuf[0], pbuf[1], pbuf[2], w_new};
                            rk_idx   <= RK_IDX_W'(i >> 2);
                            rk_valid <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench for aes_key_schedule_seq against a FIPS-197 style
// reference expansion (GF(2^8) S-box, textbook key expansion loop).

module tb_aes_key_schedule_seq;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, start2 = 1'b0;
    logic [1:0]    key_mode = 2'b00;
    logic [255:0]  key = '0;
    logic          abort = 1'b0;
    logic          rk_ready = 1'b1;
    logic [127:0]  rk_data, rk_data2;
    logic [IW-1:0] rk_idx, rk_idx2;
    logic          rk_valid, rk_valid2, busy, busy2, done, done2, err, err2;

    int total = 0;
    int bad = 0;

    logic [31:0]  ref_w [60];
    logic [127:0] got_rk [15];

    aes_key_schedule_seq #(.MODE_MASK(3'b111), .RK_IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_mode(key_mode), .key(key),
        .abort(abort), .rk_data(rk_data), .rk_idx(rk_idx), .rk_valid(rk_valid),
        .rk_ready(rk_ready), .busy(busy), .done(done), .err(err)
    );

    aes_key_schedule_seq #(.MODE_MASK(3'b001), .RK_IDX_W(IW)) dut_masked (
        .clk(clk), .rst_n(rst_n), .start(start2), .key_mode(key_mode), .key(key),
        .abort(abort), .rk_data(rk_data2), .rk_idx(rk_idx2), .rk_valid(rk_valid2),
        .rk_ready(rk_ready), .busy(busy2), .done(done2), .err(err2)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        if (a != 8'h00)
            for (int b = 1; b < 256; b++)
                if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
            {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
    endfunction

    function automatic void expand(input logic [1:0] m, input logic [255:0] kin);
        int nk;
        int nw;
        logic [31:0] t;
        logic [7:0] rc;
        nk = (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
        nw = 4 * (nk + 7);
        for (int n = 0; n < nw; n++) begin
            if (n < nk) begin
                ref_w[n] = kin[255 - 32*n -: 32];
            end else begin
                t = ref_w[n-1];
                if (n % nk == 0) begin
                    rc = 8'h01;
                    for (int q = 1; q < n / nk; q++) rc = xtime(rc);
                    t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                end else if (nk == 8 && n % nk == 4) begin
                    t = subword(t);
                end
                ref_w[n] = ref_w[n-nk] ^ t;
            end
        end
    endfunction

    function automatic logic [127:0] ref_rk(input int r);
        return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
    endfunction

    // ---------------- scenario runner ----------------
    // abort_at >= 0 aborts in the cycle round key abort_at is presented;
    // poke pulses a foreign start and changes key/key_mode mid-run.
    task automatic run_schedule(input logic [1:0] m, input logic [255:0] kin,
                                input int stall_pct, input int abort_at, input bit poke);
        int nr, k, exp_r;
        bit fin, pv, pr;
        logic [127:0] pd;
        logic [IW-1:0] pi;
        nr = (m == 2'b00) ? 10 : (m == 2'b01) ? 12 : 14;
        expand(m, kin);
        @(negedge clk);
        key = kin; key_mode = m; start = 1'b1; rk_ready = 1'b1; abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start got=%b exp=1", busy); end
        k = 0; exp_r = 0; fin = 0; pv = 0; pr = 0; pd = '0; pi = '0;
        while (!fin && k < 1500) begin
            if (rk_valid) begin
                if (pv && !pr) begin
                    total++;
                    if (rk_data !== pd || rk_idx !== pi) begin
                        bad++;
                        $display("FAIL stall_stable got=%0d:%h exp=%0d:%h", rk_idx, rk_data, pi, pd);
                    end
                end else begin
                    total++;
                    if (rk_idx !== IW'(exp_r) || exp_r > nr) begin
                        bad++; $display("FAIL rk_idx got=%0d exp=%0d", rk_idx, exp_r);
                    end
                    total++;
                    if (rk_data !== ref_rk(exp_r)) begin
                        bad++; $display("FAIL rk_data r=%0d got=%h exp=%h", exp_r, rk_data, ref_rk(exp_r));
                    end
                    if (stall_pct == 0) begin
                        total++;
                        if (k != 4*exp_r + 4) begin
                            bad++; $display("FAIL rk_timing r=%0d got=%0d exp=%0d", exp_r, k, 4*exp_r + 4);
                        end
                    end
                    if (exp_r < 15) got_rk[exp_r] = rk_data;
                end
            end
            if (poke && k == 9) begin
                start = 1'b1; key_mode = 2'b10; key = {$urandom, $urandom, $urandom, $urandom,
                                                       $urandom, $urandom, $urandom, $urandom};
            end else if (poke && k == 10) begin
                start = 1'b0;
            end
            rk_ready = ($urandom_range(99) >= stall_pct);
            if (abort_at >= 0 && rk_valid && rk_idx == IW'(abort_at)) begin
                abort = 1'b1; rk_ready = 1'b1;
            end
            #1;
            if (abort) begin
                total++;
                if (done !== 1'b0) begin bad++; $display("FAIL done_on_abort got=%b exp=0", done); end
                @(negedge clk);
                abort = 1'b0;
                total++;
                if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0) begin
                    bad++;
                    $display("FAIL after_abort got=busy%b/valid%b/done%b exp=0/0/0", busy, rk_valid, done);
                end
                rk_ready = 1'b1;
                return;
            end
            if (done) begin
                total++;
                if (!(rk_valid && rk_ready) || exp_r != nr) begin
                    bad++; $display("FAIL done_point got=r%0d exp=r%0d", exp_r, nr);
                end
                fin = 1;
            end
            if (rk_valid && rk_ready) exp_r++;
            pv = rk_valid; pr = rk_ready; pd = rk_data; pi = rk_idx;
            @(negedge clk);
            k++;
        end
        rk_ready = 1'b1;
        total++;
        if (!fin) begin bad++; $display("FAIL done_timeout got=none exp=done within 1500 cycles"); end
        total++;
        if (exp_r != nr + 1) begin bad++; $display("FAIL key_count got=%0d exp=%0d", exp_r, nr + 1); end
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL after_done got=busy%b/done%b exp=0/0", busy, done);
        end
        for (int n = 0; n < 4; n++) begin
            total++;
            if (rk_valid !== 1'b0) begin bad++; $display("FAIL key_after_done got=%b exp=0", rk_valid); end
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    localparam logic [255:0] KEY_A1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_A2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    task automatic test_reset;
        #2;
        total++;
        if (rk_data !== '0 || rk_idx !== '0 || rk_valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_outputs got=%h/%0d/%b%b%b%b exp=all zero",
                            rk_data, rk_idx, rk_valid, busy, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips_a1;
        run_schedule(2'b00, KEY_A1, 0, -1, 0);
        total++;
        if (got_rk[0] !== KEY_A1[255:128]) begin bad++; $display("FAIL a1_rk0 got=%h exp=%h", got_rk[0], KEY_A1[255:128]); end
        total++;
        if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            bad++; $display("FAIL a1_rk1 got=%h exp=a0fafe1788542cb123a339392a6c7605", got_rk[1]);
        end
        total++;
        if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            bad++; $display("FAIL a1_rk10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
        end
    endtask

    task automatic test_fips_a2;
        run_schedule(2'b01, KEY_A2, 0, -1, 0);
        total++;
        if (got_rk[12] !== 128'he98ba06f448c773c8ecc720401002202) begin
            bad++; $display("FAIL a2_rk12 got=%h exp=e98ba06f448c773c8ecc720401002202", got_rk[12]);
        end
    endtask

    task automatic test_fips_a3;
        run_schedule(2'b10, KEY_A3, 0, -1, 0);
        total++;
        if (got_rk[2][127:96] !== 32'h9ba35411) begin bad++; $display("FAIL a3_w8 got=%h exp=9ba35411", got_rk[2][127:96]); end
        total++;
        if (got_rk[3][127:96] !== 32'ha8b09c1a) begin bad++; $display("FAIL a3_w12 got=%h exp=a8b09c1a", got_rk[3][127:96]); end
        total++;
        if (got_rk[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            bad++; $display("FAIL a3_rk14 got=%h exp=fe4890d1e6188d0b046df344706c631e", got_rk[14]);
        end
    endtask

    task automatic test_stall;
        run_schedule(2'b00, KEY_A1, 50, -1, 0);
    endtask

    task automatic test_random_keys;
        logic [255:0] rk;
        for (int n = 0; n < 3; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_schedule(2'(n), rk, 30, -1, 0);
        end
    endtask

    task automatic test_errors;
        @(negedge clk);
        key_mode = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL err_mode11 got=err%b/busy%b exp=1/0", err, busy); end
        @(negedge clk);
        total++;
        if (err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL err_pulse_width got=err%b/busy%b exp=0/0", err, busy); end
        for (int m = 1; m < 3; m++) begin
            key_mode = 2'(m); start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            total++;
            if (err2 !== 1'b1 || busy2 !== 1'b0) begin
                bad++; $display("FAIL err_masked mode=%0d got=err%b/busy%b exp=1/0", m, err2, busy2);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_during_run;
        run_schedule(2'b00, KEY_A1, 0, -1, 1);
    endtask

    task automatic test_abort;
        run_schedule(2'b00, KEY_A1, 0, 3, 0);
        run_schedule(2'b00, KEY_A1, 0, -1, 0);
        run_schedule(2'b10, KEY_A3, 0, 14, 0);
        run_schedule(2'b00, KEY_A1, 20, -1, 0);
    endtask

    task automatic test_reset_midrun;
        @(negedge clk);
        key = KEY_A1; key_mode = 2'b00; start = 1'b1; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (rk_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL midrun_active got=valid%b/busy%b exp=1/1", rk_valid, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (rk_data !== '0 || rk_idx !== '0 || rk_valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL async_reset got=%h/%0d/%b%b%b%b exp=all zero",
                            rk_data, rk_idx, rk_valid, busy, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fips_a1();
        test_fips_a2();
        test_fips_a3();
        test_stall();
        test_random_keys();
        test_errors();
        test_start_during_run();
        test_abort();
        test_reset_midrun();
        test_fips_a1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
